// File: rtl/sipo_phase_scan_drp_if.sv
// DRP bus between the phase-scan initiator (master) and the measurement
// block's DRP slave port.
interface sipo_phase_scan_drp_if #(
    parameter int DRP_ABITS = 8
);
    logic                 drp_en;
    logic                 drp_we;
    logic [DRP_ABITS-1:0] drp_addr;
    logic [15:0]          drp_di;
    logic                 drp_rdy;
    logic [15:0]          drp_do;

    modport master (
        output drp_en, drp_we, drp_addr, drp_di,
        input  drp_rdy, drp_do
    );

    modport slave (
        input  drp_en, drp_we, drp_addr, drp_di,
        output drp_rdy, drp_do
    );
endinterface

// File: rtl/sipo_phase_scan_drp.sv
// DRP initiator for one SIPO-to-xclk phase measurement: writes the 32-bit
// data-line mask and the timer, polls the early counter until its busy MSB
// clears, then reads the late counter. Exactly one DRP transaction is ever
// outstanding; every wait on drp_rdy is bounded by RDY_TIMEOUT.
module sipo_phase_scan_drp #(
    parameter int DRP_ABITS      = 8,
    parameter int DRP_MASK_ADDR  = 0,
    parameter int DRP_TIMER_ADDR = 8,
    parameter int DRP_EARLY_ADDR = 9,
    parameter int DRP_LATE_ADDR  = 10,
    parameter int SETTLE_CYCLES  = 16,
    parameter int POLL_INTERVAL  = 8,
    parameter int RDY_TIMEOUT    = 64,
    parameter int MAX_POLLS      = 4095
) (
    input  logic                         drp_clk,
    input  logic                         drp_rst,
    input  logic                         start,
    input  logic [31:0]                  mask,
    input  logic [15:0]                  duration,
    output logic                         busy,
    output logic                         done,
    output logic                         error,
    output logic [14:0]                  early_cnt,
    output logic [14:0]                  late_cnt,
    sipo_phase_scan_drp_if.master        drp
);

    localparam int PW = $clog2(MAX_POLLS + 1);

    localparam logic [DRP_ABITS-1:0] A_M0  = DRP_ABITS'(DRP_MASK_ADDR);
    localparam logic [DRP_ABITS-1:0] A_M1  = DRP_ABITS'(DRP_MASK_ADDR + 1);
    localparam logic [DRP_ABITS-1:0] A_TMR = DRP_ABITS'(DRP_TIMER_ADDR);
    localparam logic [DRP_ABITS-1:0] A_E   = DRP_ABITS'(DRP_EARLY_ADDR);
    localparam logic [DRP_ABITS-1:0] A_L   = DRP_ABITS'(DRP_LATE_ADDR);

    typedef enum logic [3:0] {
        IDLE, WR_M0, WR_M1, WR_TMR, SETTLE, RD_E, POLL_GAP, RD_L, FIN
    } state_t;

    state_t               state, state_n;
    logic [15:0]          cnt;        // settle / poll gap / rdy timeout, restarts on every state change
    logic [PW-1:0]        poll_cnt;
    logic [31:0]          mask_q;
    logic [15:0]          dur_q;
    logic                 drp_en_q;
    logic                 tmo;
    logic                 err_set, poll_inc, early_cap, late_cap;
    logic                 we_c;
    logic [DRP_ABITS-1:0] addr_c;
    logic [15:0]          di_c;

    // States that own a DRP transaction; drp_rdy is only meaningful in these.
    function automatic logic is_txn(input state_t s);
        return (s == WR_M0) || (s == WR_M1) || (s == WR_TMR) || (s == RD_E) || (s == RD_L);
    endfunction

    assign tmo = (int'(cnt) + 1 >= RDY_TIMEOUT);

    // Next-state decode plus one-cycle side-effect strobes.
    always_comb begin
        state_n   = state;
        err_set   = 1'b0;
        poll_inc  = 1'b0;
        early_cap = 1'b0;
        late_cap  = 1'b0;
        case (state)
            IDLE:     if (start) state_n = WR_M0;
            WR_M0:    if (drp.drp_rdy) state_n = WR_M1;
                      else if (tmo) begin err_set = 1'b1; state_n = FIN; end
            WR_M1:    if (drp.drp_rdy) state_n = WR_TMR;
                      else if (tmo) begin err_set = 1'b1; state_n = FIN; end
            WR_TMR:   if (drp.drp_rdy) state_n = SETTLE;
                      else if (tmo) begin err_set = 1'b1; state_n = FIN; end
            SETTLE:   if (int'(cnt) + 1 >= SETTLE_CYCLES) state_n = RD_E;
            RD_E: begin
                if (drp.drp_rdy) begin
                    if (drp.drp_do[15]) begin
                        poll_inc = 1'b1;
                        state_n  = POLL_GAP;
                    end else begin
                        early_cap = 1'b1;
                        state_n   = RD_L;
                    end
                end else if (tmo) begin
                    err_set = 1'b1;
                    state_n = FIN;
                end
            end
            POLL_GAP: if (int'(cnt) + 1 >= POLL_INTERVAL) begin
                          if (int'(poll_cnt) >= MAX_POLLS) begin
                              err_set = 1'b1;
                              state_n = FIN;
                          end else begin
                              state_n = RD_E;
                          end
                      end
            RD_L:     if (drp.drp_rdy) begin late_cap = 1'b1; state_n = FIN; end
                      else if (tmo) begin err_set = 1'b1; state_n = FIN; end
            FIN:      state_n = IDLE;
            default:  state_n = IDLE;
        endcase
    end

    // Bus fields are a pure function of state, so they hold from drp_en until drp_rdy.
    always_comb begin
        we_c   = 1'b0;
        addr_c = '0;
        di_c   = '0;
        case (state)
            WR_M0:  begin we_c = 1'b1; addr_c = A_M0;  di_c = mask_q[15:0];  end
            WR_M1:  begin we_c = 1'b1; addr_c = A_M1;  di_c = mask_q[31:16]; end
            WR_TMR: begin we_c = 1'b1; addr_c = A_TMR; di_c = dur_q;         end
            RD_E:   addr_c = A_E;
            RD_L:   addr_c = A_L;
            default: ;
        endcase
    end

    // State, counters, latched request and captured results.
    always_ff @(posedge drp_clk) begin
        if (drp_rst) begin
            state     <= IDLE;
            cnt       <= '0;
            poll_cnt  <= '0;
            mask_q    <= '0;
            dur_q     <= '0;
            drp_en_q  <= 1'b0;
            error     <= 1'b0;
            early_cnt <= '0;
            late_cnt  <= '0;
        end else begin
            state    <= state_n;
            // One strobe on entry to each transaction state.
            drp_en_q <= is_txn(state_n) && (state_n != state);
            cnt      <= (state_n != state || state == IDLE) ? 16'd0 : cnt + 1'b1;
            if (state == IDLE && start) begin
                mask_q   <= mask;
                dur_q    <= duration;
                error    <= 1'b0;
                poll_cnt <= '0;
            end
            if (poll_inc)  poll_cnt  <= poll_cnt + 1'b1;
            if (err_set)   error     <= 1'b1;
            if (early_cap) early_cnt <= drp.drp_do[14:0];
            if (late_cap)  late_cnt  <= drp.drp_do[14:0];
        end
    end

    assign busy          = (state != IDLE) && (state != FIN);
    assign done          = (state == FIN);
    assign drp.drp_en    = drp_en_q;
    assign drp.drp_we    = we_c;
    assign drp.drp_addr  = addr_c;
    assign drp.drp_di    = di_c;

endmodule
